// File: rtl/keypad_multitap_encoder.sv
// keypad_multitap_encoder: scans a 4x3 phone keypad, debounces it and turns
// multi-tap digit presses into ASCII letters with commit/clear/submit pulses.
//
// Output handshake: there is no backpressure. letter is meaningful only in the
// cycle letter_valid is high. letter_valid, clear, word_submit and error are
// single-cycle registered pulses, and at most one of them is high per cycle.
module keypad_multitap_encoder #(
    parameter int SCAN_CYCLES     = 100,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int TAP_TIMEOUT     = 50000,
    parameter int AUTO_COMMIT     = 0,
    parameter int CNT_W           = 17
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [3:0] row,
    output logic [2:0] col,
    output logic [7:0] pending,
    output logic [7:0] letter,
    output logic       letter_valid,
    output logic       clear,
    output logic       word_submit,
    output logic       error,
    output logic [1:0] fsm_state
);

    localparam logic [1:0] S_SCAN        = 2'd0;
    localparam logic [1:0] S_DEB_PRESS   = 2'd1;
    localparam logic [1:0] S_PRESSED     = 2'd2;
    localparam logic [1:0] S_DEB_RELEASE = 2'd3;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TAP_LAST  = CNT_W'(TAP_TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] scan_cnt;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] tap_cnt;
    logic [1:0]       row_idx;   // latched row, 0 = R0
    logic             seq_open;
    logic [3:0]       seq_key;
    logic [1:0]       tap_idx;

    logic [1:0] det_idx;
    logic [1:0] row_sel;
    logic       sample;
    logic [1:0] col_idx;
    logic [3:0] digit;
    logic       is_digit;
    logic       is_one;
    logic       is_star;
    logic       is_zero;
    logic       is_hash;
    logic [1:0] max_idx;
    logic [1:0] new_idx;
    logic       tap_fire;

    // First letter of each digit key, offset by the tap index.
    function automatic logic [7:0] letter_of(input logic [3:0] d, input logic [1:0] idx);
        logic [7:0] base;
        case (d)
            4'd2:    base = 8'h41;
            4'd3:    base = 8'h44;
            4'd4:    base = 8'h47;
            4'd5:    base = 8'h4A;
            4'd6:    base = 8'h4D;
            4'd7:    base = 8'h50;
            4'd8:    base = 8'h54;
            4'd9:    base = 8'h57;
            default: base = 8'h00;
        endcase
        return base + {6'd0, idx};
    endfunction

    assign fsm_state = state;
    // row[3] is R0, so the latched row index maps to bit (3 - row_idx).
    assign row_sel   = ~row_idx;
    assign sample    = row[row_sel];
    assign tap_fire  = (state == S_SCAN) && seq_open && (tap_cnt == TAP_LAST);

    // Pick the winning row (R0 first) and decode the latched key.
    always_comb begin
        if (row[3])      det_idx = 2'd0;
        else if (row[2]) det_idx = 2'd1;
        else if (row[1]) det_idx = 2'd2;
        else             det_idx = 2'd3;

        if (col[2])      col_idx = 2'd0;
        else if (col[1]) col_idx = 2'd1;
        else             col_idx = 2'd2;

        digit    = 4'd1 + 4'(row_idx) * 4'd3 + 4'(col_idx);
        is_one   = (row_idx == 2'd0) && (col_idx == 2'd0);
        is_digit = (row_idx != 2'd3) && !is_one;
        is_star  = (row_idx == 2'd3) && (col_idx == 2'd0);
        is_zero  = (row_idx == 2'd3) && (col_idx == 2'd1);
        is_hash  = (row_idx == 2'd3) && (col_idx == 2'd2);

        max_idx  = ((digit == 4'd7) || (digit == 4'd9)) ? 2'd3 : 2'd2;
        if (seq_open && (seq_key == digit))
            new_idx = (tap_idx == max_idx) ? 2'd0 : tap_idx + 2'd1;
        else
            new_idx = 2'd0;
    end

    // Column scan and press/release debounce state machine.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state    <= S_SCAN;
            col      <= 3'b100;
            scan_cnt <= '0;
            deb_cnt  <= '0;
            row_idx  <= 2'd0;
        end else begin
            case (state)
                S_SCAN: begin
                    if (|row) begin
                        state    <= S_DEB_PRESS;
                        row_idx  <= det_idx;
                        deb_cnt  <= '0;
                        scan_cnt <= '0;
                    end else if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        col      <= {col[0], col[2:1]};
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                S_DEB_PRESS: begin
                    if (!sample)                  state   <= S_SCAN;
                    else if (deb_cnt == DEB_LAST) state   <= S_PRESSED;
                    else                          deb_cnt <= deb_cnt + 1'b1;
                end
                S_PRESSED: begin
                    state   <= S_DEB_RELEASE;
                    deb_cnt <= '0;
                end
                default: begin
                    if (sample)                   deb_cnt <= '0;
                    else if (deb_cnt == DEB_LAST) state   <= S_SCAN;
                    else                          deb_cnt <= deb_cnt + 1'b1;
                end
            endcase
        end
    end

    // Key actions, tap sequence tracking, tap timer and output pulses.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pending      <= 8'h00;
            letter       <= 8'h00;
            letter_valid <= 1'b0;
            clear        <= 1'b0;
            word_submit  <= 1'b0;
            error        <= 1'b0;
            seq_open     <= 1'b0;
            seq_key      <= 4'd0;
            tap_idx      <= 2'd0;
            tap_cnt      <= '0;
        end else begin
            letter_valid <= 1'b0;
            clear        <= 1'b0;
            word_submit  <= 1'b0;
            error        <= 1'b0;
            if (state == S_PRESSED) begin
                tap_cnt <= '0;
                if (is_digit) begin
                    seq_open <= 1'b1;
                    seq_key  <= digit;
                    tap_idx  <= new_idx;
                    pending  <= letter_of(digit, new_idx);
                end else if (is_star) begin
                    if (pending != 8'h00) begin
                        letter       <= pending;
                        letter_valid <= 1'b1;
                    end else begin
                        error <= 1'b1;
                    end
                    pending  <= 8'h00;
                    seq_open <= 1'b0;
                end else if (is_zero) begin
                    pending  <= 8'h00;
                    seq_open <= 1'b0;
                    clear    <= 1'b1;
                end else if (is_hash) begin
                    word_submit <= 1'b1;
                end else begin
                    error <= 1'b1;
                end
            end else if (tap_fire) begin
                seq_open <= 1'b0;
                tap_cnt  <= '0;
                if ((AUTO_COMMIT != 0) && (pending != 8'h00)) begin
                    letter       <= pending;
                    letter_valid <= 1'b1;
                    pending      <= 8'h00;
                end
            end else if ((state == S_SCAN) && seq_open) begin
                tap_cnt <= tap_cnt + 1'b1;
            end
        end
    end

endmodule
